// File: rtl/rank_select_pkg.sv
// Shared helpers for the weighted order-statistics kernel: rank width and the
// slice convention of the packed ranks vector (position j at [j*RANK_W +: RANK_W]).
package rank_select_pkg;

    function automatic int rank_width(input int n);
        return $clog2(n + 1);
    endfunction

    function automatic int rank_lsb(input int j, input int rank_w);
        return j * rank_w;
    endfunction

endpackage

// File: rtl/rank_match.sv
// Combinational compare of every position's rank against k, reduced to a
// priority one-hot (lowest index wins) plus a hit flag.
module rank_match
    import rank_select_pkg::*;
#(
    parameter int N      = 7,
    parameter int RANK_W = rank_width(N)
) (
    input  logic [RANK_W*N-1:0] ranks,
    input  logic [RANK_W-1:0]   k,
    output logic [N-1:0]        match,
    output logic                hit
);

    // k = 0 never matches, so masked-out positions (rank 0) are never selected
    always_comb begin
        match = '0;
        hit   = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!hit && (k != '0) && (ranks[rank_lsb(j, RANK_W) +: RANK_W] == k)) begin
                match[j] = 1'b1;
                hit      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rank_select.sv
// Back end of the order-statistics filter: sample window aligned with the rank
// matrix, a two-stage pipeline, and selection of the sample whose rank equals k.
module rank_select
    import rank_select_pkg::*;
#(
    parameter int N      = 7,
    parameter int DATA_W = 8,
    parameter int RANK_W = rank_width(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [DATA_W-1:0]   in_sample,
    input  logic [RANK_W*N-1:0] ranks,
    input  logic [RANK_W-1:0]   k,
    output logic                out_valid,
    output logic [DATA_W-1:0]   out_sample,
    output logic                out_miss
);

    localparam int FILL_W = $clog2(N + 1);

    logic [DATA_W-1:0] win  [N];
    logic [DATA_W-1:0] snap [N];
    logic [FILL_W-1:0] fill;
    logic              full_after_push;
    logic              pushed_full;
    logic [N-1:0]      match_c;
    logic [N-1:0]      match_q;
    logic              hit_c;
    logic              hit_q;
    logic              v1;
    logic [DATA_W-1:0] sel_sample;

    rank_match #(
        .N      (N),
        .RANK_W (RANK_W)
    ) u_rank_match (
        .ranks (ranks),
        .k     (k),
        .match (match_c),
        .hit   (hit_c)
    );

    assign full_after_push = (fill == FILL_W'(N - 1)) || (fill == FILL_W'(N));

    // Window shift register and saturating fill counter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N; j++) win[j] <= '0;
            fill        <= '0;
            pushed_full <= 1'b0;
        end else begin
            pushed_full <= in_valid && full_after_push;
            if (in_valid) begin
                for (int j = 0; j < N - 1; j++) win[j] <= win[j + 1];
                win[N-1] <= in_sample;
                if (fill != FILL_W'(N)) fill <= fill + 1'b1;
            end
        end
    end

    // Stage 1: ranks and k now describe the post-push window, so freeze both together
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < N; j++) snap[j] <= '0;
            match_q <= '0;
            hit_q   <= 1'b0;
            v1      <= 1'b0;
        end else begin
            v1 <= pushed_full;
            if (pushed_full) begin
                for (int j = 0; j < N; j++) snap[j] <= win[j];
                match_q <= match_c;
                hit_q   <= hit_c;
            end
        end
    end

    always_comb begin
        sel_sample = '0;
        for (int j = 0; j < N; j++) begin
            if (match_q[j]) sel_sample = sel_sample | snap[j];
        end
    end

    // Stage 2: data outputs only move with a result, otherwise they hold
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_sample <= '0;
            out_miss   <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                out_sample <= hit_q ? sel_sample : '0;
                out_miss   <= !hit_q;
            end
        end
    end

endmodule
